sliding_window_ctrl: RTL and testbench

SLIDING_WINDOW_CTRL -- requirements
Module: sliding_window_ctrl

---
 rtl/sliding_window_ctrl.sv | 155 +++++++++++++++
 tb/tb_sliding_window_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_ctrl.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream.
// KSIZE+1 line buffers let one line fill while the other KSIZE are read.
// A line is counted as occupied from its last written pixel until its last window
// has been consumed.
module sliding_window_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned KSIZE  = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DATA_W-1:0]                 i_pixel,
  input  logic                              i_pixel_valid,
  output logic                              o_pixel_ready,
  output logic [KSIZE*KSIZE*DATA_W-1:0]     o_window,
  output logic                              o_window_valid,
  input  logic                              i_window_ready,
  output logic                              o_line_done,
  output logic [$clog2(KSIZE+2)-1:0]        o_lines_full
);

  localparam int unsigned NUM_LB = KSIZE + 1;
  localparam int unsigned LB_W   = $clog2(NUM_LB);
  localparam int unsigned COL_W  = $clog2(LINE_W);
  localparam int unsigned CNT_W  = $clog2(NUM_LB + 1);

  localparam logic [COL_W-1:0] WR_LAST    = COL_W'(LINE_W - 1);
  localparam logic [COL_W-1:0] RD_LAST    = COL_W'(LINE_W - KSIZE);
  localparam logic [LB_W-1:0]  LB_LAST    = LB_W'(NUM_LB - 1);
  localparam logic [LB_W:0]    NUM_LB_EXT = (LB_W + 1)'(NUM_LB);
  localparam logic [CNT_W-1:0] CNT_K      = CNT_W'(KSIZE);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NUM_LB);

  typedef enum logic {StIdle, StRead} state_e;

  logic [DATA_W-1:0] r_buf [NUM_LB][LINE_W];
  logic [COL_W-1:0]  r_wr_col;
  logic [LB_W-1:0]   r_wr_lb;
  logic [COL_W-1:0]  r_rd_col;
  logic [LB_W-1:0]   r_rd_lb;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;
  logic              r_line_done;
  state_e            r_state;
  state_e            w_state_d;

  logic w_wr_en;
  logic w_wr_line;
  logic w_rd_en;
  logic w_rd_line;

  assign o_pixel_ready = (r_cnt < CNT_MAX);
  assign o_lines_full  = r_cnt;
  assign o_line_done   = r_line_done;

  assign w_wr_en   = i_pixel_valid & o_pixel_ready;
  assign w_wr_line = w_wr_en & (r_wr_col == WR_LAST);
  assign w_rd_en   = o_window_valid & i_window_ready;
  assign w_rd_line = w_rd_en & (r_rd_col == RD_LAST);

  // Buffer storage is never reset; the line count alone says what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_lb][r_wr_col] <= i_pixel;
    end
  end

  // Write pointer: column within the line, then buffer index modulo NUM_LB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_col <= '0;
      r_wr_lb  <= '0;
    end else if (w_wr_en) begin
      if (r_wr_col == WR_LAST) begin
        r_wr_col <= '0;
        r_wr_lb  <= (r_wr_lb == LB_LAST) ? '0 : r_wr_lb + LB_W'(1);
      end else begin
        r_wr_col <= r_wr_col + COL_W'(1);
      end
    end
  end

  // Read pointer: window column, then oldest-line buffer index modulo NUM_LB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_col <= '0;
      r_rd_lb  <= '0;
    end else if (w_rd_en) begin
      if (r_rd_col == RD_LAST) begin
        r_rd_col <= '0;
        r_rd_lb  <= (r_rd_lb == LB_LAST) ? '0 : r_rd_lb + LB_W'(1);
      end else begin
        r_rd_col <= r_rd_col + COL_W'(1);
      end
    end
  end

  // Occupied-line count; a simultaneous fill and drain cancel out.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_wr_line && !w_rd_line) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end else if (!w_wr_line && w_rd_line) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  // Line count and end-of-line pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_line_done <= w_rd_line;
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Read FSM next state; stays in READ across lines while enough lines remain.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (r_cnt >= CNT_K) w_state_d = StRead;
      StRead: if (w_rd_line && (w_cnt_d < CNT_K)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    o_window_valid = (r_state == StRead);
  end

  // Window taps: row r reads buffer (rd_lb + r) mod NUM_LB, columns rd_col..rd_col+KSIZE-1.
  for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
    logic [LB_W:0]   w_row_sum;
    logic [LB_W-1:0] w_row_lb;
    assign w_row_sum = {1'b0, r_rd_lb} + (LB_W + 1)'(gr);
    assign w_row_lb  = (w_row_sum >= NUM_LB_EXT) ? LB_W'(w_row_sum - NUM_LB_EXT)
                                                 : LB_W'(w_row_sum);
    for (genvar gc = 0; gc < KSIZE; gc++) begin : g_col
      assign o_window[(gr*KSIZE+gc)*DATA_W +: DATA_W] = r_buf[w_row_lb][r_rd_col + COL_W'(gc)];
    end
  end

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Self-checking bench: directed fill/full/reset scenarios plus random traffic,
// all compared against a line-queue reference model.
module tb_sliding_window_ctrl;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int K  = 3;
  localparam int NLB = K + 1;

  logic             i_clk;
  logic             i_rst;
  logic [DW-1:0]    i_pixel;
  logic             i_pixel_valid;
  logic             o_pixel_ready;
  logic [K*K*DW-1:0] o_window;
  logic             o_window_valid;
  logic             i_window_ready;
  logic             o_line_done;
  logic [2:0]       o_lines_full;

  sliding_window_ctrl #(.DATA_W(DW), .LINE_W(LW), .KSIZE(K)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .o_pixel_ready  (o_pixel_ready),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .i_window_ready (i_window_ready),
    .o_line_done    (o_line_done),
    .o_lines_full   (o_lines_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: completed lines concatenated oldest-first, plus the partial line.
  logic [DW-1:0] m_store[$];
  logic [DW-1:0] m_part[$];
  int            m_rd_col = 0;
  int            m_reads  = 0;
  bit            m_valid  = 0;
  bit            m_done   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic int m_lines();
    return m_store.size() / LW;
  endfunction

  function automatic logic [K*K*DW-1:0] exp_window();
    logic [K*K*DW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = m_store[r*LW + m_rd_col + c];
    return w;
  endfunction

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic step(input bit rst, input bit pv, input logic [DW-1:0] pix, input bit wr);
    int  n_old;
    bit  acc_pix;
    bit  acc_win;
    bit  was_valid;
    i_rst = rst; i_pixel_valid = pv; i_pixel = pix; i_window_ready = wr;
    if (rst) begin
      m_store.delete(); m_part.delete();
      m_rd_col = 0; m_reads = 0; m_valid = 0; m_done = 0;
    end else begin
      n_old     = m_lines();
      was_valid = m_valid;
      acc_pix   = pv && (n_old < NLB);
      acc_win   = m_valid && wr;
      m_done    = acc_win && (m_rd_col == LW - K);
      if (acc_win) begin
        if (m_rd_col == LW - K) begin
          for (int i = 0; i < LW; i++) void'(m_store.pop_front());
          m_rd_col = 0;
          m_reads++;
        end else begin
          m_rd_col++;
        end
      end
      if (acc_pix) begin
        m_part.push_back(pix);
        if (m_part.size() == LW) begin
          foreach (m_part[i]) m_store.push_back(m_part[i]);
          m_part.delete();
        end
      end
      // Windows flow whenever K lines are held; leaving idle costs one cycle.
      m_valid = (m_lines() >= K) && (was_valid || n_old >= K);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_eq("window_valid", o_window_valid, m_valid);
    check_eq("lines_full", o_lines_full, m_lines());
    check_eq("pixel_ready", o_pixel_ready, m_lines() < NLB);
    check_eq("line_done", o_line_done, m_done);
    if (m_valid) check_eq("window", o_window, exp_window());
  endtask

  // First window of a stream of pixels 0,1,2,...: rows {0,1,2},{8,9,10},{16,17,18}.
  task automatic check_first_window(input string tag);
    logic [K*K*DW-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'(r*LW + c);
    check_eq(tag, o_window, w);
  endtask

  initial begin
    int p;
    bit seen;
    bit wrap_done;
    i_rst = 1; i_pixel = '0; i_pixel_valid = 0; i_window_ready = 0;
    @(negedge i_clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("rst_ready", o_pixel_ready, 1);
    check_eq("rst_full", o_lines_full, 0);

    // Fill, initial backpressure, simultaneous line completion, wrap-around.
    p = 0; seen = 0; wrap_done = 0;
    for (int i = 0; i < 100; i++) begin
      bit pv;
      pv = (p < 48);
      step(0, pv, DW'(p), i >= 26);
      if (pv && o_lines_full <= 4 && (m_part.size() != 0 || m_lines() > 0)) ;
      if (pv && (i < 24 || p < 48)) begin
        if (m_store.size() + m_part.size() + m_reads*LW > p) p++;
      end
      if (o_window_valid && !seen) begin
        seen = 1;
        check_first_window("fill_first_win");
        check_eq("fill_latency", i, 24);
      end
      if (i == 31) begin
        check_eq("simul_cnt", o_lines_full, 3);
        check_eq("simul_valid", o_window_valid, 1);
      end
      if (o_window_valid && m_reads == 3 && m_rd_col == 0 && !wrap_done) begin
        wrap_done = 1;
        check_eq("wrap_row0", o_window[DW-1:0], 24);
      end
    end
    check_eq("fill_seen", seen, 1);
    check_eq("wrap_seen", wrap_done, 1);

    // Full: 32 pixels with reads blocked, then drain one line.
    step(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, DW'(i), 0);
    check_eq("full_cnt", o_lines_full, 4);
    check_eq("full_ready", o_pixel_ready, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check_eq("drain_ready", o_pixel_ready, 1);
    check_eq("drain_cnt", o_lines_full, 3);

    // Reset during the read of window column 3, then refill.
    step(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 1, DW'(i), 1);
    for (int i = 0; i < 20; i++) begin
      if (m_valid && m_rd_col == 3) break;
      step(0, 0, 0, 1);
    end
    check_eq("pre_rst_valid", o_window_valid, 1);
    step(1, 0, 0, 1);
    check_eq("rst_mid_valid", o_window_valid, 0);
    check_eq("rst_mid_full", o_lines_full, 0);
    check_eq("rst_mid_ready", o_pixel_ready, 1);
    p = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, p < 24, DW'(p), 1);
      if (p < 24) p++;
      if (o_window_valid && !seen) begin
        seen = 1;
        check_first_window("refill_first_win");
      end
    end
    check_eq("refill_seen", seen, 1);

    // Random traffic.
    step(1, 0, 0, 0);
    for (int i = 0; i < 1500; i++)
      step(0, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
